rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one synchronous ROM (one-cycle registered read, as used for the note table and pattern ROMs) among NUM_REQ requesters, e.g. the pitch lookups and pattern sequencers of several channels.
- Round-robin arbitration, pipelined: up to one new read issued per cycle, with at most one read outstanding per requester.
- Sits between the channel datapaths and a single rom_sync instance, so multi-channel builds need one ROM instead of one per channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 8, ROM address width
- DATA_WIDTH, 16, ROM data width

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_req  input  NUM_REQ  per-requester read request, level
- i_addr  input  NUM_REQ*ADDR_WIDTH  requester k address in bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- o_grant  output  NUM_REQ  one-hot, one-cycle pulse: request accepted
- o_valid  output  NUM_REQ  one-hot, one-cycle pulse: o_data holds requester k's word
- o_data  output  DATA_WIDTH  read data, shared by all requesters
- o_rom_addr  output  ADDR_WIDTH  registered address to ROM
- i_rom_data  input  DATA_WIDTH  ROM data, valid one cycle after o_rom_addr

Behaviour:
- Reset (i_rst_n low, async): o_grant=0, o_valid=0, o_data=0, o_rom_addr=0, priority pointer=0, outstanding mask=0, pipeline tags invalid. Any in-flight read is discarded with no o_valid.
- Eligible set at each edge = i_req & ~outstanding, using pre-edge register values.
- Round-robin winner: first eligible index searching pointer, pointer+1, ... modulo NUM_REQ.
- At grant edge E0:
  - o_grant[k]=1 for one cycle.
  - o_rom_addr = i_addr slice k.
  - outstanding[k] set.
  - stage-1 tag = {valid, k}.
  - pointer = (k+1) mod NUM_REQ.
- No eligible request: o_grant=0, pointer unchanged, o_rom_addr holds, stage-1 tag invalid.
- E1: stage-1 tag copied to stage-2; ROM registers its output.
- E2: o_data = i_rom_data and o_valid[k]=1 for one cycle. Latency grant→valid = 2 cycles.
- Without a valid stage-2 tag: o_valid=0, o_data holds its last value.
- E3 (end of the o_valid cycle): outstanding[k] cleared. Arbitration at E3 still sees k masked.
- Requester protocol:
  - Hold i_req high and i_addr stable until o_grant. Address is captured at grant; it may change afterwards.
  - Deassert i_req registered on o_valid. The deassert is seen at E4, so no duplicate grant occurs.
  - If i_req is still high at E4, that is a new request.
- Withdrawal: i_req dropped before grant → no grant, no valid, no state change.
- Throughput: one grant per cycle when ≥1 requester is eligible.
  - Per-requester minimum spacing between grants is 4 cycles.
  - NUM_REQ=4 with all requesters continuously requesting sustains 1 read/cycle.
- Simultaneous events:
  - A grant at edge E may coincide with an o_valid for another requester and with an outstanding clear. All updates apply independently.
  - o_grant and o_valid may both be nonzero in one cycle, for different indices.
- Pointer wrap: after granting index NUM_REQ-1, pointer = 0.
- Reset mid-read: deassertion restarts arbitration from pointer 0. Requesters must re-request, since pending reads return no valid.

Test Plan:
- Single read: ROM[0x12]=0xBEEF; req[1] with addr 0x12 at edge 0 → o_grant=4'b0010 at cycle 1, o_rom_addr=0x12, o_valid=4'b0010 with o_data=0xBEEF at cycle 3; no second grant while req[1] is dropped on valid.
- Round-robin fairness: all 4 requesting continuously, each deasserting on its valid and re-raising immediately → grant order 0,1,2,3,0,1,… with one grant per cycle; each valid carries ROM[addr_k].
- Pointer skip: pointer=2, only req[0] and req[1] high → grant 0 then 1; pointer ends at 2.
- Outstanding mask: req[2] held high through o_valid → exactly one grant before E4; a second grant occurs only if req[2] is still high at E4.
- Withdrawal: req[3] pulsed for one cycle while requester 0 owns the edge → no grant[3], no valid[3].
- Async reset: assert i_rst_n low between grant and valid → all outputs 0 immediately, no o_valid after release, first post-reset grant goes to the lowest-index requester.

Source files
------------

// File: rtl/rom_read_arbiter_if.sv
// rom_read_arbiter_if
//   Bus between the channel requesters, the shared-ROM arbiter and the ROM
//   data return.
//   i_req      : per-requester read request (level)
//   i_addr     : packed requester addresses, slice k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_grant    : one-hot pulse, request accepted
//   o_valid    : one-hot pulse, o_data belongs to requester k
//   o_data     : shared read data
//   o_rom_addr : registered ROM address
//   i_rom_data : ROM output, valid one cycle after o_rom_addr
//   slave modport  = arbiter side, master modport = requesters + ROM side.
interface rom_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
  logic [NUM_REQ-1:0]            o_grant;
  logic [NUM_REQ-1:0]            o_valid;
  logic [DATA_WIDTH-1:0]         o_data;
  logic [ADDR_WIDTH-1:0]         o_rom_addr;
  logic [DATA_WIDTH-1:0]         i_rom_data;

  modport slave (
    input  i_req, i_addr, i_rom_data,
    output o_grant, o_valid, o_data, o_rom_addr
  );

  modport master (
    output i_req, i_addr, i_rom_data,
    input  o_grant, o_valid, o_data, o_rom_addr
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Round-robin, pipelined sharing of one registered-output ROM among
//   NUM_REQ requesters. One new read may issue per cycle; each requester has
//   at most one read in flight. Grant-to-valid latency is 2 cycles.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : rom_read_arbiter_if.slave (requests, grants, valids, data, ROM port)
module rom_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  rom_read_arbiter_if.slave   bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    r_outst;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_valid;
  logic [PW-1:0]         r_ptr;
  logic                  r_s1_vld;
  logic [PW-1:0]         r_s1_idx;
  logic                  r_s2_vld;
  logic [PW-1:0]         r_s2_idx;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [NUM_REQ-1:0]    w_vld_oh;
  logic                  w_found;
  logic [PW-1:0]         w_win;
  logic [PW-1:0]         w_idx;
  logic [PW:0]           w_sum;
  logic [PW-1:0]         w_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_win_addr;

  always_comb begin
    w_elig     = bus.i_req & ~r_outst;
    w_found    = 1'b0;
    w_win      = '0;
    w_idx      = '0;
    w_sum      = '0;
    w_win_addr = '0;
    w_gnt_oh   = '0;
    w_vld_oh   = '0;
    w_ptr_nxt  = r_ptr;

    // Scan pointer, pointer+1, ... with explicit wrap (NUM_REQ need not be 2^n).
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NUM_REQ))
        w_sum = w_sum - (PW+1)'(NUM_REQ);
      w_idx = w_sum[PW-1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found    = 1'b1;
        w_win      = w_idx;
        w_win_addr = bus.i_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end

    if (w_found) begin
      w_gnt_oh[w_win] = 1'b1;
      w_ptr_nxt       = (w_win == PW'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
    end

    if (r_s2_vld)
      w_vld_oh[r_s2_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outst    <= '0;
      r_grant    <= '0;
      r_valid    <= '0;
      r_ptr      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_idx   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_idx   <= '0;
      r_rom_addr <= '0;
      r_data     <= '0;
    end else begin
      r_grant  <= w_gnt_oh;
      r_ptr    <= w_ptr_nxt;
      r_s1_vld <= w_found;
      r_s1_idx <= w_win;
      r_s2_vld <= r_s1_vld;
      r_s2_idx <= r_s1_idx;
      r_valid  <= w_vld_oh;
      if (w_found)
        r_rom_addr <= w_win_addr;
      if (r_s2_vld)
        r_data <= bus.i_rom_data;
      // Clear happens at the edge that ends the o_valid cycle, so the
      // arbitration at that same edge still sees the requester masked.
      r_outst <= (r_outst & ~r_valid) | w_gnt_oh;
    end
  end

  assign bus.o_grant    = r_grant;
  assign bus.o_valid    = r_valid;
  assign bus.o_data     = r_data;
  assign bus.o_rom_addr = r_rom_addr;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter
//   Directed bench for rom_read_arbiter with a behavioural one-cycle ROM.
module tb_rom_read_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  logic [DW-1:0] rom_q;
  int total;
  int bad;

  rom_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return (a == 8'h12) ? 16'hBEEF : {~a, a};
  endfunction

  always @(posedge clk) rom_q <= rom_word(bus.o_rom_addr);
  assign bus.i_rom_data = rom_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  g;
    logic [3:0]  v;
    logic [7:0]  ra;
    logic [15:0] d;
  } vec_t;

  vec_t vt[19];
  localparam logic [31:0] ADDRS = {8'h40, 8'h30, 8'h12, 8'h05};

  logic [7:0] cur[4];
  logic [7:0] cap;
  logic [3:0] exp_g;
  logic [3:0] exp_v;
  logic       p0v, p1v;
  logic [1:0] p0i, p1i;
  logic [7:0] p0a, p1a;
  int         e;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_req  = '0;
    bus.i_addr = ADDRS;

    // single read, pointer skip, withdrawal
    vt[0]  = '{4'b0010, 4'b0010, 4'b0000, 8'h12, 16'h0000};
    vt[1]  = '{4'b0010, 4'b0000, 4'b0000, 8'h12, 16'h0000};
    vt[2]  = '{4'b0010, 4'b0000, 4'b0010, 8'h12, 16'hBEEF};
    vt[3]  = '{4'b0000, 4'b0000, 4'b0000, 8'h12, 16'hBEEF};
    vt[4]  = '{4'b0000, 4'b0000, 4'b0000, 8'h12, 16'hBEEF};
    vt[5]  = '{4'b0011, 4'b0001, 4'b0000, 8'h05, 16'hBEEF};
    vt[6]  = '{4'b0011, 4'b0010, 4'b0000, 8'h12, 16'hBEEF};
    vt[7]  = '{4'b0011, 4'b0000, 4'b0001, 8'h12, 16'hFA05};
    vt[8]  = '{4'b0010, 4'b0000, 4'b0010, 8'h12, 16'hBEEF};
    vt[9]  = '{4'b0000, 4'b0000, 4'b0000, 8'h12, 16'hBEEF};
    vt[10] = '{4'b1011, 4'b1000, 4'b0000, 8'h40, 16'hBEEF};
    vt[11] = '{4'b1000, 4'b0000, 4'b0000, 8'h40, 16'hBEEF};
    vt[12] = '{4'b1000, 4'b0000, 4'b1000, 8'h40, 16'hBF40};
    vt[13] = '{4'b0000, 4'b0000, 4'b0000, 8'h40, 16'hBF40};
    vt[14] = '{4'b1001, 4'b0001, 4'b0000, 8'h05, 16'hBF40};
    vt[15] = '{4'b0001, 4'b0000, 4'b0000, 8'h05, 16'hBF40};
    vt[16] = '{4'b0001, 4'b0000, 4'b0001, 8'h05, 16'hFA05};
    vt[17] = '{4'b0000, 4'b0000, 4'b0000, 8'h05, 16'hFA05};
    vt[18] = '{4'b0000, 4'b0000, 4'b0000, 8'h05, 16'hFA05};

    repeat (3) step();
    chk("rst_grant", 32'(bus.o_grant), 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_data", 32'(bus.o_data), 32'h0);
    chk("rst_romaddr", 32'(bus.o_rom_addr), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      bus.i_req = vt[i].req;
      step();
      chk($sformatf("v%0d_grant", i), 32'(bus.o_grant), 32'(vt[i].g));
      chk($sformatf("v%0d_valid", i), 32'(bus.o_valid), 32'(vt[i].v));
      chk($sformatf("v%0d_romaddr", i), 32'(bus.o_rom_addr), 32'(vt[i].ra));
      chk($sformatf("v%0d_data", i), 32'(bus.o_data), 32'(vt[i].d));
    end

    // Fairness: all requesting, pointer starts at 1; addresses change after grant.
    cur[0] = 8'h05; cur[1] = 8'h12; cur[2] = 8'h30; cur[3] = 8'h40;
    bus.i_addr = {cur[3], cur[2], cur[1], cur[0]};
    bus.i_req  = 4'b1111;
    e = 1;
    p0v = 1'b0; p1v = 1'b0; p0i = '0; p1i = '0; p0a = '0; p1a = '0; cap = '0;
    for (int t = 0; t < 20; t++) begin
      step();
      exp_g = (t < 16) ? (4'b0001 << e) : 4'b0000;
      exp_v = p1v ? (4'b0001 << p1i) : 4'b0000;
      chk($sformatf("rr%0d_grant", t), 32'(bus.o_grant), 32'(exp_g));
      chk($sformatf("rr%0d_valid", t), 32'(bus.o_valid), 32'(exp_v));
      if (p1v)
        chk($sformatf("rr%0d_data", t), 32'(bus.o_data), 32'(rom_word(p1a)));
      if (t < 16) begin
        cap = cur[e];
        chk($sformatf("rr%0d_romaddr", t), 32'(bus.o_rom_addr), 32'(cap));
      end
      p1v = p0v; p1i = p0i; p1a = p0a;
      p0v = (t < 16); p0i = 2'(e); p0a = cap;
      if (t < 16) begin
        cur[e] = cur[e] + 8'h11;
        bus.i_addr = {cur[3], cur[2], cur[1], cur[0]};
        e = (e + 1) % 4;
      end
      if (t == 15) bus.i_req = 4'b0000;
    end

    // Outstanding mask: req[2] held through its valid, dropped after the second valid.
    bus.i_addr = ADDRS;
    bus.i_req  = 4'b0100;
    for (int t = 0; t < 11; t++) begin
      step();
      exp_g = (t == 0 || t == 4) ? 4'b0100 : 4'b0000;
      exp_v = (t == 2 || t == 6) ? 4'b0100 : 4'b0000;
      chk($sformatf("om%0d_grant", t), 32'(bus.o_grant), 32'(exp_g));
      chk($sformatf("om%0d_valid", t), 32'(bus.o_valid), 32'(exp_v));
      chk($sformatf("om%0d_romaddr", t), 32'(bus.o_rom_addr), 32'h30);
      if (exp_v != 4'b0000)
        chk($sformatf("om%0d_data", t), 32'(bus.o_data), 32'h0000CF30);
      if (t == 6) bus.i_req = 4'b0000;
    end

    // Async reset between grant and valid.
    bus.i_req = 4'b0100;
    step();
    chk("ar_grant_pre", 32'(bus.o_grant), 32'h4);
    bus.i_req = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(bus.o_grant), 32'h0);
    chk("ar_valid", 32'(bus.o_valid), 32'h0);
    chk("ar_data", 32'(bus.o_data), 32'h0);
    chk("ar_romaddr", 32'(bus.o_rom_addr), 32'h0);
    step();
    step();
    chk("ar_hold_valid", 32'(bus.o_valid), 32'h0);
    rst_n = 1'b1;
    bus.i_req = 4'b0011;
    for (int r = 0; r < 5; r++) begin
      step();
      exp_g = (r == 0) ? 4'b0001 : (r == 1) ? 4'b0010 : 4'b0000;
      exp_v = (r == 2) ? 4'b0001 : (r == 3) ? 4'b0010 : 4'b0000;
      chk($sformatf("pr%0d_grant", r), 32'(bus.o_grant), 32'(exp_g));
      chk($sformatf("pr%0d_valid", r), 32'(bus.o_valid), 32'(exp_v));
      chk($sformatf("pr%0d_romaddr", r), 32'(bus.o_rom_addr), (r == 0) ? 32'h05 : 32'h12);
      chk($sformatf("pr%0d_data", r), 32'(bus.o_data),
          (r < 2) ? 32'h0 : (r == 2) ? 32'hFA05 : 32'hBEEF);
      if (r == 2) bus.i_req = 4'b0010;
      if (r == 3) bus.i_req = 4'b0000;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
